// File: rtl/data_mem_pkg.sv
// Shared encodings and helpers for the KGP-RISC data memory.
// Byte lanes are little-endian: lane k of a word holds bits [8k+7:8k].
package data_mem_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE   = 2'b00,
      SZ_HALF   = 2'b01,
      SZ_WORD   = 2'b10,
      SZ_DOUBLE = 2'b11
   } size_e;

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } state_e;

   // Byte-enable mask for an access of 1<<size bytes at lane offset, clipped to nbytes lanes.
   function automatic logic [7:0] lane_mask(input logic [1:0] size,
                                            input logic [2:0] offset,
                                            input int unsigned nbytes);
      logic [15:0] m;
      m = ((16'd1 << (4'd1 << size)) - 16'd1) << offset;
      for (int unsigned b = 0; b < 8; b++) begin
         if (b >= nbytes) m[b] = 1'b0;
      end
      return m[7:0];
   endfunction

endpackage

// File: rtl/data_mem_load_align.sv
// Extracts the addressed lanes of a read word and sign/zero extends them.
// Purely combinational so it can be reused by other fill paths.
module data_mem_load_align
   import data_mem_pkg::*;
#(
   parameter  int DATA_W = 32,
   localparam int OFF_W  = $clog2(DATA_W/8)
) (
   input  logic [DATA_W-1:0] i_word,
   input  logic [OFF_W-1:0]  i_offset,
   input  logic [1:0]        i_size,
   input  logic              i_signed,
   output logic [DATA_W-1:0] o_data
);

   logic [DATA_W-1:0] w_sh;
   logic              w_fill;
   int unsigned       w_nbits;

   always_comb begin
      w_sh    = i_word >> {i_offset, 3'b000};
      w_nbits = DATA_W;
      w_fill  = 1'b0;
      o_data  = '0;
      case (i_size)
         SZ_BYTE: begin w_nbits = 8;  w_fill = w_sh[7];  end
         SZ_HALF: begin w_nbits = 16; w_fill = w_sh[15]; end
         SZ_WORD: begin w_nbits = 32; w_fill = w_sh[31]; end
         default: begin w_nbits = DATA_W; w_fill = w_sh[DATA_W-1]; end
      endcase
      w_fill = w_fill & i_signed;
      for (int unsigned i = 0; i < DATA_W; i++) begin
         o_data[i] = (i < w_nbits) ? w_sh[i] : w_fill;
      end
   end

endmodule

// File: rtl/data_mem_unit.sv
// Byte/half/word/double data memory with alignment faults, one-cycle response
// and a post-reset hardware clear sequence.
module data_mem_unit
   import data_mem_pkg::*;
#(
   parameter  int DATA_W = 32,
   parameter  int DEPTH  = 1024,
   localparam int ADDR_W = $clog2(DEPTH) + $clog2(DATA_W/8)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_fault,
   output logic              init_done
);

   localparam int NB    = DATA_W/8;
   localparam int OFF_W = $clog2(NB);
   localparam int IDX_W = $clog2(DEPTH);

   logic [DATA_W-1:0] r_mem [DEPTH];
   state_e            r_state;
   logic [IDX_W-1:0]  r_cnt;
   logic              r_ready;
   logic              r_init_done;
   logic              r_rsp_valid;
   logic              r_rsp_fault;
   logic [DATA_W-1:0] r_rsp_rdata;

   logic [IDX_W-1:0]  w_idx;
   logic [OFF_W-1:0]  w_off;
   logic [3:0]        w_bytes;
   logic              w_fault;
   logic              w_accept;
   logic              w_store;
   logic [7:0]        w_mask;
   logic [DATA_W-1:0] w_wshift;
   logic [DATA_W-1:0] w_rd_word;
   logic [DATA_W-1:0] w_ld_data;

   always_comb begin
      w_idx     = req_addr[ADDR_W-1:OFF_W];
      w_off     = req_addr[OFF_W-1:0];
      w_bytes   = 4'd1 << req_size;
      w_fault   = (|(w_off & OFF_W'(w_bytes - 4'd1))) ||
                  ((req_size == SZ_DOUBLE) && (DATA_W == 32));
      w_accept  = req_valid & r_ready;
      w_store   = w_accept & req_write & ~w_fault;
      w_mask    = lane_mask(req_size, 3'(w_off), NB);
      w_wshift  = req_wdata << {w_off, 3'b000};
      w_rd_word = r_mem[w_idx];
   end

   data_mem_load_align #(.DATA_W(DATA_W)) u_align (
      .i_word   (w_rd_word),
      .i_offset (w_off),
      .i_size   (req_size),
      .i_signed (req_signed),
      .o_data   (w_ld_data)
   );

   // Array has no reset of its own; the CLEAR state zeroes it one word per cycle.
   always_ff @(posedge clk) begin
      if (r_state == CLEAR) begin
         r_mem[r_cnt] <= '0;
      end else if (w_store) begin
         for (int unsigned b = 0; b < NB; b++) begin
            if (w_mask[b]) r_mem[w_idx][8*b +: 8] <= w_wshift[8*b +: 8];
         end
      end
   end

   // The read is taken at the accepting edge, so a store committed one edge earlier is visible.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= CLEAR;
         r_cnt       <= '0;
         r_ready     <= 1'b0;
         r_init_done <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_fault <= 1'b0;
         r_rsp_rdata <= '0;
      end else begin
         r_rsp_valid <= w_accept;
         r_rsp_fault <= w_accept & w_fault;
         r_rsp_rdata <= (w_accept && !req_write && !w_fault) ? w_ld_data : '0;
         case (r_state)
            CLEAR: begin
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == IDX_W'(DEPTH-1)) begin
                  r_state     <= RUN;
                  r_ready     <= 1'b1;
                  r_init_done <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign req_ready = r_ready;
   assign init_done = r_init_done;
   assign rsp_valid = r_rsp_valid;
   assign rsp_fault = r_rsp_fault;
   assign rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_data_mem_unit.sv
// Random plus directed checks of data_mem_unit in 32- and 64-bit builds
// against a byte-array reference model.
module tb_data_mem_unit;

   localparam int DEPTH = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b0;
   logic        sel = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_write = 1'b0;
   logic        req_signed = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic [6:0]  req_addr = '0;
   logic [63:0] req_wdata = '0;

   logic        rdy32, rv32, rf32, id32;
   logic [31:0] rd32;
   logic        rdy64, rv64, rf64, id64;
   logic [63:0] rd64;

   data_mem_unit #(.DATA_W(32), .DEPTH(DEPTH)) u_dut32 (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid & ~sel),
      .req_ready  (rdy32),
      .req_write  (req_write),
      .req_size   (req_size),
      .req_signed (req_signed),
      .req_addr   (req_addr[5:0]),
      .req_wdata  (req_wdata[31:0]),
      .rsp_valid  (rv32),
      .rsp_rdata  (rd32),
      .rsp_fault  (rf32),
      .init_done  (id32)
   );

   data_mem_unit #(.DATA_W(64), .DEPTH(DEPTH)) u_dut64 (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid & sel),
      .req_ready  (rdy64),
      .req_write  (req_write),
      .req_size   (req_size),
      .req_signed (req_signed),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rv64),
      .rsp_rdata  (rd64),
      .rsp_fault  (rf64),
      .init_done  (id64)
   );

   logic [7:0] mem32 [64];
   logic [7:0] mem64 [128];

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=0x%016h exp=0x%016h", tag, got, exp);
      end
   endtask

   // Reference: memory is a flat little-endian byte array.
   task automatic model(input logic s, input logic w, input logic [1:0] sz, input logic sg,
                        input logic [6:0] a, input logic [63:0] wd,
                        output logic f, output logic [63:0] rd);
      int unsigned nb;
      int unsigned bytes;
      int unsigned width;
      logic [63:0] v;
      nb    = s ? 8 : 4;
      width = nb * 8;
      bytes = 1 << sz;
      v     = '0;
      rd    = '0;
      f     = (bytes > nb) || ((a % bytes) != 0);
      if (f) return;
      if (w) begin
         for (int unsigned k = 0; k < bytes; k++) begin
            if (s) mem64[a + k] = wd[8*k +: 8];
            else   mem32[a + k] = wd[8*k +: 8];
         end
      end else begin
         for (int unsigned k = 0; k < bytes; k++) begin
            v = v | (64'(s ? mem64[a + k] : mem32[a + k]) << (8*k));
         end
         if (sg && v[8*bytes-1]) begin
            for (int unsigned i = 8*bytes; i < width; i++) v[i] = 1'b1;
         end
         rd = v;
      end
   endtask

   task automatic issue(input logic s, input logic w, input logic [1:0] sz, input logic sg,
                        input logic [6:0] a, input logic [63:0] wd, input string tag);
      logic        f;
      logic [63:0] e;
      if (!s) a[6] = 1'b0;
      model(s, w, sz, sg, a, wd, f, e);
      sel        = s;
      req_valid  = 1'b1;
      req_write  = w;
      req_size   = sz;
      req_signed = sg;
      req_addr   = a;
      req_wdata  = wd;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      check_eq({tag, ".valid"}, 64'(s ? rv64 : rv32), 64'd1);
      check_eq({tag, ".fault"}, 64'(s ? rf64 : rf32), 64'(f));
      check_eq({tag, ".rdata"}, s ? rd64 : {32'd0, rd32}, e);
   endtask

   task automatic idle();
      req_valid = 1'b0;
      @(posedge clk);
      #1;
      check_eq("idle", {rv32, rf32, rv64, rf64, 28'd0, rd32 | rd64[31:0] | rd64[63:32]}, 64'd0);
   endtask

   task automatic do_reset(input int unsigned hold);
      int unsigned cnt;
      rst = 1'b1;
      #1;
      check_eq("rst.out32", {26'd0, rdy32, rv32, rf32, id32, rd32}, 64'd0);
      check_eq("rst.out64", {60'd0, rdy64, rv64, rf64, id64}, 64'd0);
      check_eq("rst.rd64", rd64, 64'd0);
      repeat (hold) @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 64; i++)  mem32[i] = 8'h00;
      for (int i = 0; i < 128; i++) mem64[i] = 8'h00;
      sel       = 1'b0;
      req_valid = 1'b1;
      req_write = 1'b0;
      req_size  = 2'b10;
      req_addr  = '0;
      cnt = 0;
      while (!(rdy32 && rdy64) && cnt < 200) begin
         @(posedge clk);
         #1;
         cnt++;
         if (!(rdy32 && rdy64)) check_eq("clear.refuse", 64'(rv32), 64'd0);
      end
      req_valid = 1'b0;
      check_eq("clear.cycles", 64'(cnt), 64'(DEPTH));
      check_eq("clear.done", {62'd0, id32, id64}, 64'd3);
   endtask

   initial begin
      #2;
      do_reset(3);

      issue(0, 0, 2'b10, 0, 7'h0C, 64'd0, "clr.ld32");
      check_eq("clr.ld32.k", {32'd0, rd32}, 64'd0);
      issue(1, 0, 2'b11, 0, 7'h28, 64'd0, "clr.ld64");

      issue(0, 1, 2'b00, 0, 7'h05, 64'h80, "byte.st");
      issue(0, 0, 2'b00, 1, 7'h05, 64'd0, "byte.lds");
      check_eq("byte.lds.k", {32'd0, rd32}, 64'hFFFF_FF80);
      issue(0, 0, 2'b00, 0, 7'h05, 64'd0, "byte.ldu");
      check_eq("byte.ldu.k", {32'd0, rd32}, 64'h0000_0080);
      issue(0, 0, 2'b10, 0, 7'h04, 64'd0, "byte.ldw");
      check_eq("byte.ldw.k", {32'd0, rd32}, 64'h0000_8000);

      issue(0, 1, 2'b10, 0, 7'h10, 64'h1234_5678, "merge.stw");
      issue(0, 1, 2'b01, 0, 7'h12, 64'hBEEF, "merge.sth");
      issue(0, 0, 2'b10, 0, 7'h10, 64'd0, "merge.ldw");
      check_eq("merge.ldw.k", {32'd0, rd32}, 64'hBEEF_5678);

      issue(0, 1, 2'b01, 0, 7'h01, 64'hFFFF_FFFF, "mis.half");
      issue(0, 1, 2'b10, 0, 7'h02, 64'hFFFF_FFFF, "mis.word");
      issue(0, 1, 2'b11, 0, 7'h00, 64'hFFFF_FFFF, "mis.dbl32");
      check_eq("mis.dbl32.k", {31'd0, rf32, rd32}, 64'h1_0000_0000);
      issue(0, 0, 2'b10, 1, 7'h06, 64'd0, "mis.ld");
      issue(0, 0, 2'b10, 0, 7'h00, 64'd0, "mis.keep");
      check_eq("mis.keep.k", {32'd0, rd32}, 64'd0);
      idle();

      issue(0, 1, 2'b10, 0, 7'h20, 64'hCAFE_F00D, "b2b.st");
      issue(0, 0, 2'b10, 0, 7'h20, 64'd0, "b2b.ld");
      check_eq("b2b.ld.k", {32'd0, rd32}, 64'hCAFE_F00D);
      idle();

      issue(1, 1, 2'b11, 0, 7'h08, 64'h0123_4567_89AB_CDEF, "d64.st");
      issue(1, 0, 2'b11, 0, 7'h08, 64'd0, "d64.ld");
      check_eq("d64.ld.k", rd64, 64'h0123_4567_89AB_CDEF);
      issue(1, 0, 2'b10, 1, 7'h0C, 64'd0, "d64.ldw");
      issue(1, 0, 2'b00, 1, 7'h0B, 64'd0, "d64.ldb");
      check_eq("d64.ldb.k", rd64, 64'hFFFF_FFFF_FFFF_FF89);
      issue(1, 1, 2'b11, 0, 7'h04, 64'hFFFF, "d64.mis");

      for (int it = 0; it < 300; it++) begin
         logic        s, w, sg;
         logic [1:0]  sz;
         logic [6:0]  a;
         logic [63:0] wd;
         s  = 1'($urandom_range(0, 1));
         w  = 1'($urandom_range(0, 1));
         sg = 1'($urandom_range(0, 1));
         sz = 2'($urandom_range(0, 3));
         a  = 7'($urandom);
         wd = {$urandom, $urandom};
         if ($urandom_range(0, 3) != 0) a = a & ~7'((1 << sz) - 1);
         issue(s, w, sz, sg, a, wd, "rand");
         if ($urandom_range(0, 7) == 0) idle();
      end

      issue(0, 1, 2'b10, 0, 7'h20, 64'h5555_AAAA, "mid.st32");
      issue(1, 1, 2'b11, 0, 7'h10, 64'hDEAD_BEEF_0BAD_F00D, "mid.st64");
      sel       = 1'b0;
      req_valid = 1'b1;
      req_write = 1'b0;
      req_size  = 2'b10;
      req_addr  = 7'h20;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      check_eq("mid.pending", 64'(rv32), 64'd1);
      do_reset(2);
      issue(0, 0, 2'b10, 0, 7'h20, 64'd0, "mid.ld32");
      check_eq("mid.ld32.k", {32'd0, rd32}, 64'd0);
      issue(1, 0, 2'b11, 0, 7'h10, 64'd0, "mid.ld64");
      check_eq("mid.ld64.k", rd64, 64'd0);
      idle();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
